mux_nx1_rr: RTL and testbench
=============================

Name: mux_nx1_rr

Overview:
- Parametrised N-input, W-bit registered multiplexer with valid/ready handshake on every input channel and on the output.
- Successor to the 4x1 bit-level mux. Adds:
  - configurable channel count and data width;
  - a fixed-select mode and a round-robin mode;
  - a one-beat output register with back-pressure.
- Sits between several producer channels and a single downstream consumer.

Parameters:
- N, 4, number of input channels (2..16; need not be a power of two).
- W, 8, data width per channel in bits.
- SW, $clog2(N), select/channel-index width (localparam, derived; not overridable).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  N*W  flattened channel data; channel k occupies bits [k*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = fixed select (MODE_FIXED), 1 = round-robin (MODE_RR).
- sel  input  SW  channel index used in fixed mode; ignored in RR mode.
- out_data  output  W  registered output data.
- out_ch  output  SW  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, RR pointer ptr=0.
  - Any held beat is discarded.
  - in_ready is combinationally 0 while rst_n is low.
- load_en = !out_valid | out_ready. The register is free, or is being emptied this cycle.
- Grant, computed combinationally:
  - Fixed mode: grant = sel if sel < N and in_valid[sel]; otherwise no grant.
  - RR mode: grant = first k with in_valid[k] set, searching ptr, ptr+1, ..., N-1, then 0, ..., ptr-1 (wrap-around). No grant if in_valid == 0.
- in_ready[k] = load_en & grant_valid & (grant == k). Each in_ready bit depends only on in_valid, mode, sel, ptr, out_valid and out_ready. It never depends on in_data.
- Transfer on input k = in_valid[k] & in_ready[k]. On the next edge: out_data <= channel k data, out_ch <= k, out_valid <= 1.
- If load_en and no grant: out_valid <= 0 on the next edge. The beat is consumed when out_ready is high; otherwise the register stays empty.
- If !load_en: the output register holds. out_data and out_ch are stable while out_valid & !out_ready.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle when out_ready is held high.
- ptr update, RR mode only: after a transfer from channel g, ptr <= (g == N-1) ? 0 : g+1. Fixed mode never modifies ptr.
- Mode or sel change: takes effect on the next arbitration. A beat already held is unaffected.
- sel >= N (possible when N is not a power of two): no grant, no in_ready. No error flag.
- Simultaneous drain and load (out_valid & out_ready & new transfer): the register is replaced with the new beat and out_valid stays 1, with no bubble.
- Reset mid-operation: held data is lost. After release, arbitration restarts from ptr=0.

Decomposition:
- Shared package mux_pkg:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - Helper function for the channel-index width.
- Sub-module rr_arb:
  - Purely combinational.
  - Inputs: req[N], ptr[SW]. Outputs: gnt_valid, gnt_idx[SW].
  - Implemented as a rotate, priority-encode, un-rotate.
- mux_nx1_rr instantiates rr_arb and contains the fixed-select path, the output register, ptr and the handshake logic.

Test Plan:
- Reset/idle: rst_n=0 with in_valid=4'b1111 → out_valid=0, out_data=0, out_ch=0, in_ready=0. Release; first edge with out_ready=1 → out_valid=1.
- Fixed mode, N=4, W=8: in_data = {8'h33, 8'h22, 8'h11, 8'h00}, all valid, out_ready=1. Step sel 0→1→2→3, one per cycle → out_data 00, 11, 22, 33 one cycle after each sel, with out_ch matching. Deassert in_valid[3] while sel=3 → out_valid drops.
- Round-robin fairness: mode=1, all valid, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3. Then in_valid=4'b1010 → alternating 1,3,1,3.
- Back-pressure: out_ready=0 for 3 cycles while a beat from ch2 (8'h22) is held → out_data/out_ch stable, in_ready=0. Raise out_ready → next beat is ch3 (RR), with no beat lost or duplicated.
- Wrap/sparse: ptr=3, in_valid=4'b0001 → grant ch0, ptr becomes 1. Mid-stream rst_n pulse → out_valid=0 asynchronously; after release the first RR grant is the lowest valid channel from 0.
- Non-power-of-two: N=3, mode=0, sel=3 with all valid → in_ready=0 and out_valid falls to 0 after the held beat drains.

Source files
------------

// File: rtl/mux_nx1_rr_pkg.sv
// Shared definitions for the N-input round-robin / fixed-select mux.
// Holds the mode encodings and the channel-index width helper.
// No ports; imported by the arbiter, interface and top.
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Channel-index width for n channels. Never returns less than one bit,
   // so a select port always exists.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Handshake bundle between N producers, the mux and one consumer.
// master: producer/consumer side (drives in_*, mode, sel, out_ready).
// slave : mux side (drives in_ready and the out_* beat).
interface mux_nx1_rr_if #(
   parameter int N = 4,
   parameter int W = 8
);
   import mux_pkg::*;

   localparam int SW = idx_w(N);

   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_ch;
   logic           out_valid;
   logic           out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );

endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
// Ports: req[N] requests, ptr start index; gnt_valid/gnt_idx winning channel.
// Zero latency; no backpressure (pure function of req and ptr).
module rr_arb
   import mux_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic          gnt_valid,
   output logic [SW-1:0] gnt_idx
);

   logic [N-1:0]  rot;
   logic [SW-1:0] off;

   // Rotate so that ptr lands at bit 0, pick the lowest set bit, then map
   // the offset back to an absolute channel. Modulo is done by a single
   // conditional subtract because ptr and the offset are both below N.
   always_comb begin
      int j;
      int idx;
      rot       = '0;
      off       = '0;
      gnt_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         rot[i] = req[j];
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            gnt_valid = 1'b1;
            off       = SW'(i);
         end
      end
      idx = int'(ptr) + int'(off);
      if (idx >= N) idx = idx - N;
      gnt_idx = SW'(idx);
   end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-input W-bit registered mux, fixed-select or round-robin arbitration.
// Latency: 1 cycle input transfer to out_valid; 1 beat/cycle with out_ready high.
// Backpressure: in_ready only when output register is empty or draining this cycle.
// Ports: clk, rst_n (async active-low), bus (slave view of mux_nx1_rr_if).
module mux_nx1_rr
   import mux_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = 8,
   localparam int SW = idx_w(N)
) (
   input logic           clk,
   input logic           rst_n,
   mux_nx1_rr_if.slave   bus
);

   logic          load_en;
   logic          fix_vld;
   logic          rr_vld;
   logic [SW-1:0] rr_idx;
   logic          gnt_vld;
   logic [SW-1:0] gnt_idx;
   logic [W-1:0]  gnt_dat;
   logic [N-1:0]  rdy;
   logic [SW-1:0] ptr;

   logic          out_vld_q;
   logic [W-1:0]  out_dat_q;
   logic [SW-1:0] out_ch_q;

   rr_arb #(.N(N)) u_rr_arb (
      .req       (bus.in_valid),
      .ptr       (ptr),
      .gnt_valid (rr_vld),
      .gnt_idx   (rr_idx)
   );

   // Fixed path: compare sel against every legal index so an out-of-range
   // sel (N not a power of two) simply matches nothing.
   always_comb begin
      fix_vld = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (bus.sel == SW'(k) && bus.in_valid[k]) fix_vld = 1'b1;
      end
   end

   assign gnt_vld = (bus.mode == MODE_RR) ? rr_vld : fix_vld;
   assign gnt_idx = (bus.mode == MODE_RR) ? rr_idx : bus.sel;
   assign load_en = !out_vld_q || bus.out_ready;

   // Ready never looks at in_data, and is forced low while held in reset.
   always_comb begin
      rdy     = '0;
      gnt_dat = '0;
      for (int k = 0; k < N; k++) begin
         rdy[k] = rst_n && load_en && gnt_vld && (gnt_idx == SW'(k));
         if (gnt_idx == SW'(k)) gnt_dat = bus.in_data[k*W +: W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
         out_ch_q  <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         if (gnt_vld) begin
            out_vld_q <= 1'b1;
            out_dat_q <= gnt_dat;
            out_ch_q  <= gnt_idx;
            if (bus.mode == MODE_RR) begin
               ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
            end
         end else begin
            out_vld_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = out_vld_q;
   assign bus.out_data  = out_dat_q;
   assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr: N=4 instance plus an N=3 instance.
// Expected values are hand-derived constants per step.
// Ports: none (top-level bench).
module tb_mux_nx1_rr;
   import mux_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   errs = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mux_nx1_rr_if #(.N(4), .W(8)) bus ();
   mux_nx1_rr_if #(.N(3), .W(8)) bus3 ();

   mux_nx1_rr #(.N(4), .W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mux_nx1_rr #(.N(3), .W(8)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_d;
      // reset / idle
      rst_n          = 1'b0;
      bus.in_data    = {8'h33, 8'h22, 8'h11, 8'h00};
      bus.in_valid   = 4'b1111;
      bus.mode       = MODE_FIXED;
      bus.sel        = 2'd0;
      bus.out_ready  = 1'b1;
      bus3.in_data   = {8'hc2, 8'hb1, 8'ha0};
      bus3.in_valid  = 3'b111;
      bus3.mode      = MODE_FIXED;
      bus3.sel       = 2'd2;
      bus3.out_ready = 1'b1;
      #12;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data",  bus.out_data,  0);
      chk("rst_out_ch",    bus.out_ch,    0);
      chk("rst_in_ready",  bus.in_ready,  0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready",  bus.in_ready,  4'b0001);

      // fixed mode, step sel 0..3
      tick();
      chk("fix0_valid", bus.out_valid, 1);
      chk("fix0_data",  bus.out_data,  8'h00);
      chk("fix0_ch",    bus.out_ch,    0);
      for (int s = 1; s < 4; s++) begin
         bus.sel = 2'(s);
         tick();
         exp_d = 8'(8'h11 * s);
         chk("fix_data", bus.out_data, exp_d);
         chk("fix_ch",   bus.out_ch,   s);
      end
      bus.in_valid = 4'b0111;
      #1;
      chk("fix3_in_ready", bus.in_ready, 0);
      tick();
      chk("fix3_drop", bus.out_valid, 0);

      // round-robin fairness, ptr still 0 (fixed mode never moves it)
      bus.mode     = MODE_RR;
      bus.in_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         tick();
         exp_d = 8'(8'h11 * (i % 4));
         chk("rr_ch",   bus.out_ch,   i % 4);
         chk("rr_data", bus.out_data, exp_d);
      end
      bus.in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr_sparse_ch", bus.out_ch, (i % 2 == 0) ? 1 : 3);
      end

      // back-pressure while ch2 beat is held (ptr back at 0)
      bus.in_valid = 4'b1111;
      tick();
      chk("bp_pre0", bus.out_ch, 0);
      tick();
      chk("bp_pre1", bus.out_ch, 1);
      tick();
      chk("bp_ch2", bus.out_ch, 2);
      bus.out_ready = 1'b0;
      #1;
      chk("bp_in_ready", bus.in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_valid", bus.out_valid, 1);
         chk("bp_hold_data",  bus.out_data,  8'h22);
         chk("bp_hold_ch",    bus.out_ch,    2);
         chk("bp_hold_rdy",   bus.in_ready,  0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", bus.in_ready, 4'b1000);
      tick();
      chk("bp_next_ch",   bus.out_ch,   3);
      chk("bp_next_data", bus.out_data, 8'h33);

      // wrap: get ptr to 3 then only ch0 valid
      bus.in_valid = 4'b0100;
      tick();
      chk("wrap_pre_ch", bus.out_ch, 2);
      bus.in_valid = 4'b0001;
      #1;
      chk("wrap_rdy", bus.in_ready, 4'b0001);
      tick();
      chk("wrap_ch", bus.out_ch, 0);
      bus.in_valid = 4'b1111;
      tick();
      chk("wrap_ptr1_ch", bus.out_ch, 1);

      // mid-stream async reset
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_rdy",   bus.in_ready,  0);
      chk("mid_rst_ch",    bus.out_ch,    0);
      bus.in_valid = 4'b0110;
      #2;
      rst_n = 1'b1;
      #1;
      chk("post_rst_rdy", bus.in_ready, 4'b0010);
      tick();
      chk("post_rst_ch",   bus.out_ch,   1);
      chk("post_rst_data", bus.out_data, 8'h11);

      // N=3: sel=2 beat held, then sel=3 (out of range)
      chk("n3_held_valid", bus3.out_valid, 1);
      chk("n3_held_data",  bus3.out_data,  8'hc2);
      chk("n3_held_ch",    bus3.out_ch,    2);
      bus3.sel = 2'd3;
      #1;
      chk("n3_sel3_rdy",   bus3.in_ready,  0);
      chk("n3_sel3_valid", bus3.out_valid, 1);
      tick();
      chk("n3_drained", bus3.out_valid, 0);
      tick();
      chk("n3_stays_empty", bus3.out_valid, 0);
      chk("n3_rdy_still0",  bus3.in_ready,  0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
